// File: rtl/vga_dither_out_if.sv
// rtl/vga_dither_out_if.sv - pixel bus between the rbzero core and the dithered VGA output stage
//
// Purpose: bundles the core-side pixel/sync/blank inputs and the aligned VGA-side outputs.
// Signals (core side -> output stage):
//   i_rgb[5:0]    {b[1:0],g[1:0],r[1:0]} colour
//   i_hsync_n     active-low hsync
//   i_vsync_n     active-low vsync
//   i_hblank      horizontal blank
//   i_vblank      vertical blank
//   i_hpos0       hpos[0] of the current pixel
//   i_vpos0       vpos[0] of the current pixel
//   i_dither_en   1: ordered dither, 0: channel MSB
// Signals (output stage -> board):
//   o_rgb[5:0]    registered, blank-masked colour
//   o_rgb1[2:0]   {b,g,r}, 1 bit per channel
//   o_hsync_n     delayed hsync
//   o_vsync_n     delayed vsync
//   o_frame       frames completed since reset
// Modports: master = core/bench side, slave = vga_dither_out.
interface vga_dither_out_if #(
    parameter int FRAME_BITS = 8
);
    logic [5:0]            i_rgb;
    logic                  i_hsync_n;
    logic                  i_vsync_n;
    logic                  i_hblank;
    logic                  i_vblank;
    logic                  i_hpos0;
    logic                  i_vpos0;
    logic                  i_dither_en;
    logic [5:0]            o_rgb;
    logic [2:0]            o_rgb1;
    logic                  o_hsync_n;
    logic                  o_vsync_n;
    logic [FRAME_BITS-1:0] o_frame;

    modport master (
        output i_rgb, i_hsync_n, i_vsync_n, i_hblank, i_vblank,
               i_hpos0, i_vpos0, i_dither_en,
        input  o_rgb, o_rgb1, o_hsync_n, o_vsync_n, o_frame
    );

    modport slave (
        input  i_rgb, i_hsync_n, i_vsync_n, i_hblank, i_vblank,
               i_hpos0, i_vpos0, i_dither_en,
        output o_rgb, o_rgb1, o_hsync_n, o_vsync_n, o_frame
    );
endinterface

// File: rtl/vga_dither_out.sv
// rtl/vga_dither_out.sv - equal-latency VGA output stage with blank masking, 2x2 ordered dither and frame counter
//
// Purpose: registers the core's colour and syncs through PIPE_STAGES aligned stages, forces
// black during blanking, produces a 1-bit-per-channel ordered-dithered colour alongside the
// undithered 6-bit colour, and counts frames on vblank rising edges.
// Optional feature macro: TEMPORAL_DITHER_EN (rotates the Bayer threshold by o_frame[1:0]).
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    vga_dither_out_if.slave: i_* pixel inputs, o_* aligned outputs
// Parameters:
//   PIPE_STAGES  total register stages input to output (1..4)
//   FRAME_BITS   frame counter width (must match the interface)
module vga_dither_out #(
    parameter int PIPE_STAGES = 1,
    parameter int FRAME_BITS  = 8
) (
    input  logic           clk,
    input  logic           reset,
    vga_dither_out_if.slave bus
);

    typedef struct packed {
        logic [5:0] rgb;
        logic [2:0] rgb1;
        logic       hsync_n;
        logic       vsync_n;
    } pix_t;

    localparam pix_t PIX_RESET = '{rgb: 6'd0, rgb1: 3'd0, hsync_n: 1'b1, vsync_n: 1'b1};

    pix_t                  pipe [PIPE_STAGES];
    pix_t                  stage0_d;
    logic [FRAME_BITS-1:0] frame_q;
    logic                  prev_vblank;

    logic                  blank;
    logic [1:0]            c_r, c_g, c_b;
    logic [1:0]            bayer;
    logic [1:0]            bt;

    // Pattern [[0,2],[3,1]] indexed by (vpos0, hpos0).
    assign bayer = {bus.i_vpos0 ^ bus.i_hpos0, bus.i_vpos0};

`ifdef TEMPORAL_DITHER_EN
    logic [1:0] frame_lsb;
    generate
        if (FRAME_BITS >= 2) begin : g_frame_wide
            assign frame_lsb = frame_q[1:0];
        end else begin : g_frame_narrow
            assign frame_lsb = {1'b0, frame_q[0]};
        end
    endgenerate
    // 2-bit add wraps mod 4, so each pixel walks all four thresholds over four frames.
    assign bt = bayer + frame_lsb;
`else
    assign bt = bayer;
`endif

    // Full intensity always lights; otherwise light when the level beats the threshold.
    function automatic logic dither_bit(input logic [1:0] c, input logic [1:0] t);
        return (c == 2'd3) || (c > t);
    endfunction

    always_comb begin
        blank = bus.i_hblank | bus.i_vblank;
        c_r   = blank ? 2'd0 : bus.i_rgb[1:0];
        c_g   = blank ? 2'd0 : bus.i_rgb[3:2];
        c_b   = blank ? 2'd0 : bus.i_rgb[5:4];

        stage0_d         = PIX_RESET;
        stage0_d.rgb     = {c_b, c_g, c_r};
        stage0_d.rgb1    = bus.i_dither_en
                         ? {dither_bit(c_b, bt), dither_bit(c_g, bt), dither_bit(c_r, bt)}
                         : {c_b[1], c_g[1], c_r[1]};
        // Syncs bypass the blank mask and travel in the same stage as the colour.
        stage0_d.hsync_n = bus.i_hsync_n;
        stage0_d.vsync_n = bus.i_vsync_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pipe[i] <= PIX_RESET;
            end
            // Starting high means a reset released mid-vblank does not count a frame.
            prev_vblank <= 1'b1;
            frame_q     <= '0;
        end else begin
            pipe[0] <= stage0_d;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
            prev_vblank <= bus.i_vblank;
            if (bus.i_vblank && !prev_vblank) begin
                frame_q <= frame_q + FRAME_BITS'(1);
            end
        end
    end

    assign bus.o_rgb     = pipe[PIPE_STAGES-1].rgb;
    assign bus.o_rgb1    = pipe[PIPE_STAGES-1].rgb1;
    assign bus.o_hsync_n = pipe[PIPE_STAGES-1].hsync_n;
    assign bus.o_vsync_n = pipe[PIPE_STAGES-1].vsync_n;
    // Frame count is deliberately not pipelined.
    assign bus.o_frame   = frame_q;

endmodule

// File: tb/tb_vga_dither_out.sv
// tb/tb_vga_dither_out.sv - scoreboard bench for vga_dither_out (PIPE_STAGES=3, FRAME_BITS=2)
module tb_vga_dither_out;

    localparam int PS = 3;
    localparam int FB = 2;

    typedef struct {
        logic [5:0] rgb;
        logic [2:0] rgb1;
        logic       hs;
        logic       vs;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    vga_dither_out_if #(.FRAME_BITS(FB)) bus ();

    vga_dither_out #(.PIPE_STAGES(PS), .FRAME_BITS(FB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t          exp_q[$];
    int            tests = 0;
    int            fails = 0;
    logic [FB-1:0] exp_frame = '0;
    logic          model_prev_vb = 1'b1;
    bit            done = 1'b0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, got, want, $time);
        end
    endtask

    // One pixel per clock: drive inputs, take the edge, queue the hand-computed result.
    task automatic step(input logic rst, input logic [5:0] rgb, input logic hs, input logic vs,
                        input logic hb, input logic vb, input logic vp, input logic hp,
                        input logic den, input logic [5:0] e_rgb, input logic [2:0] e_rgb1);
        exp_t e;
        reset           = rst;
        bus.i_rgb       = rgb;
        bus.i_hsync_n   = hs;
        bus.i_vsync_n   = vs;
        bus.i_hblank    = hb;
        bus.i_vblank    = vb;
        bus.i_vpos0     = vp;
        bus.i_hpos0     = hp;
        bus.i_dither_en = den;
        @(posedge clk);
        e.rgb  = rst ? 6'd0 : e_rgb;
        e.rgb1 = rst ? 3'd0 : e_rgb1;
        e.hs   = rst ? 1'b1 : hs;
        e.vs   = rst ? 1'b1 : vs;
        exp_q.push_back(e);
        if (rst) begin
            exp_frame     = '0;
            model_prev_vb = 1'b1;
        end else begin
            if (vb && !model_prev_vb) exp_frame = exp_frame + 1'b1;
            model_prev_vb = vb;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 6'h00, 1, 1, 0, 0, 0, 0, 0, 6'h00, 3'd0);
    endtask

    // Monitor: an entry leaves the queue once its pixel has crossed all PS stages.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (done) break;
            if (exp_q.size() >= PS) begin
                e = exp_q.pop_front();
                check("o_rgb",     {2'b0, bus.o_rgb},     {2'b0, e.rgb});
                check("o_rgb1",    {5'b0, bus.o_rgb1},    {5'b0, e.rgb1});
                check("o_hsync_n", {7'b0, bus.o_hsync_n}, {7'b0, e.hs});
                check("o_vsync_n", {7'b0, bus.o_vsync_n}, {7'b0, e.vs});
            end
            check("o_frame", 8'(bus.o_frame), 8'(exp_frame));
        end
    end

    logic [5:0] sweep_rgb [3];
    logic [2:0] sweep_exp [3][4];
    logic [FB-1:0] frame_tab [5];

    initial begin
        sweep_rgb = '{6'h15, 6'h2A, 6'h3F};
        sweep_exp = '{'{3'd7, 3'd0, 3'd0, 3'd0},
                      '{3'd7, 3'd0, 3'd0, 3'd7},
                      '{3'd7, 3'd7, 3'd7, 3'd7}};
        frame_tab = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Reset during vblank, then release with the same inputs (blanked, vsync low).
        for (int i = 0; i < 3; i++) step(1, 6'h3F, 1, 0, 0, 1, 0, 0, 0, 6'h00, 3'd0);
        for (int i = 0; i < 3; i++) step(0, 6'h3F, 1, 0, 0, 1, 0, 0, 0, 6'h00, 3'd0);
        check("frame_after_reset", 8'(bus.o_frame), 8'd0);
        step(0, 6'h3F, 1, 1, 0, 0, 0, 0, 0, 6'h3F, 3'd7);

        // Single-clock hsync pulse aligned with full white.
        step(0, 6'h00, 1, 1, 0, 0, 0, 0, 0, 6'h00, 3'd0);
        step(0, 6'h3F, 0, 1, 0, 0, 0, 0, 0, 6'h3F, 3'd7);
        step(0, 6'h00, 1, 1, 0, 0, 0, 0, 0, 6'h00, 3'd0);

        // hblank masks colour only; syncs still pass.
        step(0, 6'h2A, 0, 1, 1, 0, 0, 0, 1, 6'h00, 3'd0);
        step(0, 6'h2A, 1, 0, 1, 0, 1, 1, 0, 6'h00, 3'd0);

        // Static ordered dither sweep over the 2x2 cell.
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 4; k++) begin
                step(0, sweep_rgb[s], 1, 1, 0, 0, k[1], k[0], 1, sweep_rgb[s], sweep_exp[s][k]);
            end
        end
        // Mixed levels b=3,g=2,r=1 at threshold 1.
        step(0, 6'h39, 1, 1, 0, 0, 1, 1, 1, 6'h39, 3'b110);

        // Dither off: MSB per channel, switched per pixel.
        step(0, 6'h2A, 1, 1, 0, 0, 0, 1, 0, 6'h2A, 3'b111);
        step(0, 6'h15, 1, 1, 0, 0, 0, 1, 0, 6'h15, 3'b000);
        step(0, 6'h15, 1, 1, 0, 0, 0, 0, 1, 6'h15, 3'b111);

        // Five vblank rising edges with a 2-bit counter.
        for (int k = 0; k < 5; k++) begin
            step(0, 6'h3F, 1, 0, 0, 1, 0, 0, 1, 6'h00, 3'd0);
            step(0, 6'h3F, 1, 0, 0, 1, 0, 0, 1, 6'h00, 3'd0);
            step(0, 6'h00, 1, 1, 0, 0, 0, 0, 1, 6'h00, 3'd0);
            check("frame_count", 8'(bus.o_frame), 8'(frame_tab[k]));
        end

`ifdef TEMPORAL_DITHER_EN
        // c=1 at (0,0) across frames 1,2,3,0: lit only when the rotated threshold is 0.
        for (int k = 0; k < 4; k++) begin
            step(0, 6'h15, 1, 1, 0, 0, 0, 0, 1, 6'h15, (k == 3) ? 3'd7 : 3'd0);
            step(0, 6'h00, 1, 1, 0, 1, 0, 0, 1, 6'h00, 3'd0);
            step(0, 6'h00, 1, 1, 0, 0, 0, 0, 1, 6'h00, 3'd0);
        end
`else
        // Static pattern ignores the frame count (now 1).
        step(0, 6'h15, 1, 1, 0, 0, 0, 0, 1, 6'h15, 3'd7);
        step(0, 6'h15, 1, 1, 0, 0, 1, 1, 1, 6'h15, 3'd0);
`endif

        idle(PS + 1);
        done = 1'b1;
        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
